// File: rtl/out_pkg.sv
// Shared defaults and the display-sequencer state encoding for the CPU output port.
package out_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DWELL  = 50000000;
    localparam int DEFAULT_CNT_W  = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } dispState_e;

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and an occupancy count.
module out_fifo
    import out_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == (PTR_W + 1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)
                count <= count + 1'b1;
            else if (!doPush && doPop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/out_display_queue.sv
// CPU OUT-port stage: queues writes and shows each value for a minimum dwell before the next.
module out_display_queue
    import out_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int DWELL_CYCLES = DEFAULT_DWELL,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     outWrite,
    input  logic [DATA_W-1:0]        outData,
    output logic                     outReady,
    output logic [DATA_W-1:0]        outLine,
    output logic                     exibirFlag,
    output logic                     valueNeg,
    output logic [$clog2(DEPTH):0]   queueCount,
    output logic                     overflow
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    dispState_e        state;
    dispState_e        nextState;
    logic [CNT_W-1:0]  dwellCnt;
    logic [DATA_W-1:0] fifoHead;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pushReq;
    logic              popReq;
    logic              dwellDone;

    // Ready comes only from the registered count, so a full FIFO refuses a write even if it pops that cycle.
    assign outReady  = !fifoFull;
    assign pushReq   = outWrite && outReady;
    assign dwellDone = (dwellCnt == DWELL_LAST);

    out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) fifoInst (
        .clock (clock),
        .reset (reset),
        .push  (pushReq),
        .pop   (popReq),
        .din   (outData),
        .dout  (fifoHead),
        .count (queueCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        popReq    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    popReq    = 1'b1;
                    nextState = SHOW;
                end
            end
            SHOW: begin
                if (dwellDone) begin
                    if (!fifoEmpty) popReq = 1'b1;
                    else            nextState = HOLD;
                end
            end
            HOLD: begin
                if (!fifoEmpty) begin
                    popReq    = 1'b1;
                    nextState = SHOW;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        exibirFlag = (state == SHOW) || (state == HOLD);
        valueNeg   = exibirFlag && outLine[DATA_W-1];
    end

    // The counter only runs while a value is dwelling in SHOW; every pop restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            outLine  <= '0;
            dwellCnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (popReq) outLine <= fifoHead;
            if (popReq || state != SHOW || dwellDone)
                dwellCnt <= '0;
            else
                dwellCnt <= dwellCnt + 1'b1;
            if (outWrite && !outReady) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_out_display_queue.sv
// Directed bench for out_display_queue with a 4-cycle dwell and a 4-entry queue.
module tb_out_display_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int DWELL  = 4;
    localparam int CNT_W  = 4;

    logic        clock;
    logic        reset;
    logic        outWrite;
    logic [31:0] outData;
    logic        outReady;
    logic [31:0] outLine;
    logic        exibirFlag;
    logic        valueNeg;
    logic [2:0]  queueCount;
    logic        overflow;

    int vectorCount = 0;
    int missCount   = 0;

    out_display_queue #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .outWrite   (outWrite),
        .outData    (outData),
        .outReady   (outReady),
        .outLine    (outLine),
        .exibirFlag (exibirFlag),
        .valueNeg   (valueNeg),
        .queueCount (queueCount),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, wanted %h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One write strobe accepted (or refused) at the next rising edge.
    task automatic applyStimulus(input logic [31:0] data);
        outWrite = 1'b1;
        outData  = data;
        @(posedge clock);
        #1;
        outWrite = 1'b0;
    endtask

    logic [31:0] burstExp [12];
    logic [31:0] fullExp  [19];

    initial begin
        reset    = 1'b1;
        outWrite = 1'b0;
        outData  = '0;
        waitCycles(2);
        reset = 1'b0;
        waitCycles(10);
        checkOutput("rst outLine",    outLine,           32'h0);
        checkOutput("rst exibirFlag", 32'(exibirFlag),   32'd0);
        checkOutput("rst outReady",   32'(outReady),     32'd1);
        checkOutput("rst queueCount", 32'(queueCount),   32'd0);
        checkOutput("rst overflow",   32'(overflow),     32'd0);

        // Single write: queued at edge N, on display after N+1, held afterwards.
        applyStimulus(32'h0000_007B);
        checkOutput("single queued",  32'(queueCount), 32'd1);
        checkOutput("single notyet",  32'(exibirFlag), 32'd0);
        waitCycles(1);
        checkOutput("single outLine", outLine,         32'h7B);
        checkOutput("single flag",    32'(exibirFlag), 32'd1);
        checkOutput("single neg",     32'(valueNeg),   32'd0);
        checkOutput("single popped",  32'(queueCount), 32'd0);
        waitCycles(24);
        checkOutput("hold outLine",   outLine,         32'h7B);
        checkOutput("hold flag",      32'(exibirFlag), 32'd1);

        // Burst of three: each shown exactly four cycles in order.
        burstExp = '{32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9};
        applyStimulus(32'h5);
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("burst c1", outLine, 32'h5);
        applyStimulus(32'h9);
        checkOutput("burst c2", outLine, 32'h5);
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            checkOutput($sformatf("burst c%0d line", i + 3), outLine, burstExp[i]);
            checkOutput($sformatf("burst c%0d neg", i + 3), 32'(valueNeg), 32'(burstExp[i][31]));
        end

        // Fill the queue while a prior value dwells; fifth and sixth writes are refused.
        applyStimulus(32'h20);
        applyStimulus(32'h21);
        waitCycles(2);
        for (int v = 1; v <= 4; v++) applyStimulus(32'(v));
        checkOutput("full ready", 32'(outReady),   32'd0);
        checkOutput("full count", 32'(queueCount), 32'd4);
        checkOutput("full noovf", 32'(overflow),   32'd0);
        checkOutput("full shows", outLine,         32'h21);
        applyStimulus(32'h5);
        checkOutput("drop5 ovf",  32'(overflow),   32'd1);
        applyStimulus(32'h6);
        checkOutput("drop6 count", 32'(queueCount), 32'd3);
        checkOutput("drop6 line",  outLine,         32'h1);
        checkOutput("drop6 ready", 32'(outReady),   32'd1);
        fullExp = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2, 32'h2, 32'h3, 32'h3, 32'h3, 32'h3,
                    32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4};
        for (int i = 0; i < 19; i++) begin
            waitCycles(1);
            checkOutput($sformatf("drain c%0d", i + 10), outLine, fullExp[i]);
        end
        checkOutput("drain empty",  32'(queueCount), 32'd0);
        checkOutput("drain sticky", 32'(overflow),   32'd1);

        // Write during HOLD replaces the value one cycle later and restarts the dwell.
        applyStimulus(32'h10);
        checkOutput("holdwr old",   outLine, 32'h4);
        waitCycles(1);
        checkOutput("holdwr new",   outLine, 32'h10);
        applyStimulus(32'h11);
        checkOutput("dwell c2",     outLine, 32'h10);
        waitCycles(2);
        checkOutput("dwell c4",     outLine, 32'h10);
        waitCycles(1);
        checkOutput("dwell next",   outLine, 32'h11);
        waitCycles(6);

        // Reset in the second dwell cycle of a burst with two entries waiting.
        applyStimulus(32'hA);
        applyStimulus(32'hB);
        applyStimulus(32'hC);
        checkOutput("midrst line",  outLine,         32'hA);
        checkOutput("midrst count", 32'(queueCount), 32'd2);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("postrst line",  outLine,         32'h0);
        checkOutput("postrst flag",  32'(exibirFlag), 32'd0);
        checkOutput("postrst count", 32'(queueCount), 32'd0);
        checkOutput("postrst ovf",   32'(overflow),   32'd0);
        checkOutput("postrst ready", 32'(outReady),   32'd1);
        applyStimulus(32'h0000_007B);
        checkOutput("rewr flag0", 32'(exibirFlag), 32'd0);
        waitCycles(1);
        checkOutput("rewr line",  outLine,         32'h7B);
        checkOutput("rewr flag",  32'(exibirFlag), 32'd1);
        checkOutput("rewr neg",   32'(valueNeg),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
